// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares a single SRAM macro between an instruction-fetch requester (port 0)
// and a data load/store requester (port 1). One access per cycle, round-robin
// on contention, read data returned one cycle after the grant. An optional
// zero-fill sweep clears the memory after every reset before any grant.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   m0_* / m1_*              requester ports: req/addr/web/wdata in,
//                            gnt (combinational), rvalid/rdata (registered) out
//   init_done                high while the arbiter accepts requests
//   sram_cs/oe/web/a/di      drive to the macro (macro clocks on ~clk)
//   sram_do                  read data from the macro
module sram_arbiter #(
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_SIZE   = 14,
  parameter int CLEAR_EN    = 0,
  parameter int CLEAR_DEPTH = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [3:0]           m0_web,
  input  logic [DATA_SIZE-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [DATA_SIZE-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [3:0]           m1_web,
  input  logic [DATA_SIZE-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [DATA_SIZE-1:0] m1_rdata,
  output logic                 init_done,
  output logic                 sram_cs,
  output logic                 sram_oe,
  output logic [3:0]           sram_web,
  output logic [ADDR_SIZE-1:0] sram_a,
  output logic [DATA_SIZE-1:0] sram_di,
  input  logic [DATA_SIZE-1:0] sram_do
);

  typedef enum logic [1:0] {
    START,
    CLEAR,
    ARB
  } state_t;

  localparam logic [ADDR_SIZE-1:0] CLR_LAST = ADDR_SIZE'(CLEAR_DEPTH - 1);

  state_t               state;
  state_t               next_state;
  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 last_gnt;
  logic                 gnt0;
  logic                 gnt1;
  logic                 rd0;
  logic                 rd1;
  logic                 rvalid0_q;
  logic                 rvalid1_q;
  logic [DATA_SIZE-1:0] rdata0_q;
  logic [DATA_SIZE-1:0] rdata1_q;

  // State register; reset always returns to START so a sweep interrupted by
  // reset is repeated from the beginning.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= START;
    end else begin
      state <= next_state;
    end
  end

  // Sweep address only advances while clearing and is parked at zero
  // otherwise, so every entry into CLEAR starts from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + ADDR_SIZE'(1);
    end else begin
      clr_addr <= '0;
    end
  end

  // Next state, grant decision and SRAM drive. Everything is forced to idle
  // while rst is high so reset dominates any request in the same cycle.
  // On a tie the port that was not granted last wins.
  always_comb begin
    next_state = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    sram_cs    = 1'b0;
    sram_oe    = 1'b0;
    sram_web   = 4'hF;
    sram_a     = '0;
    sram_di    = '0;
    if (!rst) begin
      case (state)
        START: begin
          next_state = (CLEAR_EN != 0) ? CLEAR : ARB;
        end
        CLEAR: begin
          sram_cs  = 1'b1;
          sram_web = 4'h0;
          sram_a   = clr_addr;
          if (clr_addr == CLR_LAST) begin
            next_state = ARB;
          end
        end
        ARB: begin
          gnt0 = m0_req && (!m1_req || last_gnt);
          gnt1 = m1_req && (!m0_req || !last_gnt);
          if (gnt0) begin
            sram_cs  = 1'b1;
            sram_oe  = (m0_web == 4'hF);
            sram_web = m0_web;
            sram_a   = m0_addr;
            sram_di  = m0_wdata;
          end else if (gnt1) begin
            sram_cs  = 1'b1;
            sram_oe  = (m1_web == 4'hF);
            sram_web = m1_web;
            sram_a   = m1_addr;
            sram_di  = m1_wdata;
          end
        end
        default: begin
          next_state = START;
        end
      endcase
    end
  end

  // Remember the most recent winner; starts at 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

  assign rd0 = gnt0 && (m0_web == 4'hF);
  assign rd1 = gnt1 && (m1_web == 4'hF);

  // The macro samples on the falling edge of the grant cycle, so its output
  // is ready to capture on the rising edge that ends that cycle. Each port
  // keeps its last read data until its own next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0) begin
        rdata0_q <= sram_do;
      end
      if (rd1) begin
        rdata1_q <= sram_do;
      end
    end
  end

  // Registered responses are masked by rst so a response due in a reset
  // cycle is dropped and outputs show reset values immediately.
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q && !rst;
  assign m1_rvalid = rvalid1_q && !rst;
  assign m0_rdata  = rst ? '0 : rdata0_q;
  assign m1_rdata  = rst ? '0 : rdata1_q;
  assign init_done = (state == ARB) && !rst;

endmodule
